// File: rtl/wb_arb2_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2_if
// Purpose  : Wishbone classic bus bundle shared by masters, arbiter and slave.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arb2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;

    // The slave fabric has no error line; only the arbiter raises err.
    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2
// Purpose  : Two-master Wishbone classic arbiter, round-robin, cyc-locked
//            grants and an ack-timeout watchdog that returns err.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_arb2_if.slave   m0,
    wb_arb2_if.slave   m1,
    wb_arb2_if.master  s,
    output logic [1:0] gnt_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_nxt;

    logic            w_g0;
    logic            w_g1;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_dat;
    logic [DW/8-1:0] w_sel;
    logic            w_we;
    logic            w_cyc;
    logic            w_stb;
    logic            w_req;
    logic            w_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A grant is only released when its owner drops cyc; ties favour !last.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || r_last)) begin
                    w_state_nxt = GNT0;
                end else if (m1.cyc) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1.cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0.cyc ? GNT0 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_g0 = (r_state == GNT0);
    assign w_g1 = (r_state == GNT1);

    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        if (w_g0) begin
            w_adr = m0.adr;
            w_dat = m0.dat_w;
            w_sel = m0.sel;
            w_we  = m0.we;
            w_cyc = m0.cyc;
            w_stb = m0.stb;
        end else if (w_g1) begin
            w_adr = m1.adr;
            w_dat = m1.dat_w;
            w_sel = m1.sel;
            w_we  = m1.we;
            w_cyc = m1.cyc;
            w_stb = m1.stb;
        end
    end

    assign w_req = w_cyc & w_stb;
    // An ack arriving on the limit cycle wins over the timeout.
    assign w_to  = w_req && (r_cnt == c_timeout) && !s.ack;

    always_comb begin
        w_cnt_nxt = r_cnt + 8'd1;
        if ((w_state_nxt != r_state) || !w_req || s.ack || w_to) begin
            w_cnt_nxt = 8'd0;
        end
    end

    assign s.adr    = w_adr;
    assign s.dat_w  = w_dat;
    assign s.sel    = w_sel;
    assign s.we     = w_we;
    assign s.cyc    = w_cyc;
    assign s.stb    = w_stb;

    assign m0.ack   = w_g0 & s.ack;
    assign m0.err   = w_g0 & w_to;
    assign m0.dat_r = w_g0 ? s.dat_r : '0;
    assign m1.ack   = w_g1 & s.ack;
    assign m1.err   = w_g1 & w_to;
    assign m1.dat_r = w_g1 ? s.dat_r : '0;

    assign gnt_o    = {w_g1, w_g0};
endmodule
`default_nettype wire

// File: tb/tb_wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arb2
// Purpose  : Self-checking bench for wb_arb2: directed vector table, a bounded
//            timeout sequence and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arb2;
    localparam int TO = 4;
    localparam logic [31:0] A0  = 32'h0300_0000;
    localparam logic [31:0] A1  = 32'h0000_1000;
    localparam logic [31:0] DAT = 32'hE59F_F018;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;

    always #5 clk = ~clk;

    wb_arb2_if #(.AW(32), .DW(32)) m0_bus ();
    wb_arb2_if #(.AW(32), .DW(32)) m1_bus ();
    wb_arb2_if #(.AW(32), .DW(32)) s_bus ();

    wb_arb2 #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .gnt_o (gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       r, c0, s0, c1, s1, ack;
        logic [1:0] gnt;
        logic       scyc, a0, a1, e0, e1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, c0, s0, c1, s1, ack,
                                input logic [1:0] g,
                                input logic scyc, a0, a1, e0, e1);
        vec_t v;
        v.r = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
        v.gnt = g; v.scyc = scyc; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Reference model state: owner (-1 idle), last winner, cycles waited.
    int   own;
    logic last_m;
    int   waitc;

    initial begin
        logic [31:0] exp_adr;
        logic        mc[2];
        logic        ms[2];
        logic [31:0] madr[2];
        logic [31:0] mdat[2];
        logic [3:0]  msel[2];
        logic        mwe[2];
        logic        sack;
        logic [31:0] sdat;
        logic        req, to;
        int          newown;
        int          idx;

        // Reset / stray ack / single m0 read
        tbl.push_back(mk(1,0,0,0,0,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1, 2'b01, 1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b01, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b00, 0,0,0,0,0));
        // Tie after reset, back-to-back handover, next tie to m0
        tbl.push_back(mk(1,0,0,0,0,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b01, 1,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 2'b01, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,1, 2'b10, 1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b10, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b01, 1,1,0,0,0));
        // Lock: m1 holds cyc over 3 phases while m0 keeps requesting
        tbl.push_back(mk(0,0,0,1,1,0, 2'b01, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b10, 1,0,1,0,0));
        tbl.push_back(mk(0,1,1,1,0,0, 2'b10, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b10, 1,0,1,0,0));
        tbl.push_back(mk(0,1,1,1,0,0, 2'b10, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b10, 1,0,1,0,0));
        tbl.push_back(mk(0,1,1,0,0,0, 2'b10, 0,0,0,0,0));
        // Timeout: err in cycle 4, then again 5 cycles later
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < TO; j++) tbl.push_back(mk(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
            tbl.push_back(mk(0,1,1,0,0,0, 2'b01, 1,0,0,1,0));
        end
        // Ack on the limit cycle beats err
        for (int j = 0; j < TO; j++) tbl.push_back(mk(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1, 2'b01, 1,1,0,0,0));
        // Reset while GNT1 with stb high, then tie goes to m0
        tbl.push_back(mk(0,0,0,1,1,0, 2'b01, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,0, 2'b10, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,0, 2'b00, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,1, 2'b01, 1,1,0,0,0));

        rst = 1'b1;
        m0_bus.adr = A0; m0_bus.dat_w = 32'h1111_1111; m0_bus.sel = 4'hF; m0_bus.we = 1'b0;
        m1_bus.adr = A1; m1_bus.dat_w = 32'h2222_2222; m1_bus.sel = 4'h3; m1_bus.we = 1'b1;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.dat_r = DAT; s_bus.ack = 1'b0; s_bus.err = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            m0_bus.cyc = tbl[i].c0; m0_bus.stb = tbl[i].s0;
            m1_bus.cyc = tbl[i].c1; m1_bus.stb = tbl[i].s1;
            s_bus.ack = tbl[i].ack;
            #1;
            exp_adr = (tbl[i].gnt == 2'b01) ? A0 : (tbl[i].gnt == 2'b10) ? A1 : 32'h0;
            check($sformatf("row%0d gnt", i),   gnt,          tbl[i].gnt);
            check($sformatf("row%0d s_cyc", i), s_bus.cyc,    tbl[i].scyc);
            check($sformatf("row%0d s_adr", i), s_bus.adr,    exp_adr);
            check($sformatf("row%0d m0_ack", i), m0_bus.ack,  tbl[i].a0);
            check($sformatf("row%0d m1_ack", i), m1_bus.ack,  tbl[i].a1);
            check($sformatf("row%0d m0_err", i), m0_bus.err,  tbl[i].e0);
            check($sformatf("row%0d m1_err", i), m1_bus.err,  tbl[i].e1);
            check($sformatf("row%0d m0_dat", i), m0_bus.dat_r, tbl[i].gnt[0] ? DAT : 32'h0);
            check($sformatf("row%0d m1_dat", i), m1_bus.dat_r, tbl[i].gnt[1] ? DAT : 32'h0);
        end

        // Hand sequence: m1 alone, slave silent; err must land in cycle TO.
        @(negedge clk);
        rst = 1'b1; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.ack = 1'b0;
        @(negedge clk);
        rst = 1'b0; m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        idx = 20;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (m1_bus.err) begin
                idx = k;
                check("m1 timeout ack low", m1_bus.ack, 1'b0);
                break;
            end
        end
        check("m1 timeout cycle", idx, TO);
        @(negedge clk);
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;

        // Randomized traffic against the reference model.
        own = -1; last_m = 1'b1; waitc = 0;
        mc[0] = 1'b0; mc[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = (n == 0) || ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0) mc[m] = ~mc[m];
                ms[m]   = ($urandom_range(0, 2) != 0);
                madr[m] = $urandom;
                mdat[m] = $urandom;
                msel[m] = 4'($urandom);
                mwe[m]  = 1'($urandom);
            end
            sack = ($urandom_range(0, 2) == 0);
            sdat = $urandom;
            m0_bus.cyc = mc[0]; m0_bus.stb = ms[0]; m0_bus.adr = madr[0];
            m0_bus.dat_w = mdat[0]; m0_bus.sel = msel[0]; m0_bus.we = mwe[0];
            m1_bus.cyc = mc[1]; m1_bus.stb = ms[1]; m1_bus.adr = madr[1];
            m1_bus.dat_w = mdat[1]; m1_bus.sel = msel[1]; m1_bus.we = mwe[1];
            s_bus.ack = sack; s_bus.dat_r = sdat;
            #1;
            req = (own >= 0) && mc[own] && ms[own];
            to  = req && (waitc == TO) && !sack;
            if (n > 0) begin
                check("rnd gnt",    gnt, (own == 1) ? 2'b10 : (own == 0) ? 2'b01 : 2'b00);
                check("rnd s_cyc",  s_bus.cyc,   (own >= 0) ? mc[own]   : 1'b0);
                check("rnd s_stb",  s_bus.stb,   (own >= 0) ? ms[own]   : 1'b0);
                check("rnd s_adr",  s_bus.adr,   (own >= 0) ? madr[own] : 32'h0);
                check("rnd s_dat",  s_bus.dat_w, (own >= 0) ? mdat[own] : 32'h0);
                check("rnd s_sel",  s_bus.sel,   (own >= 0) ? msel[own] : 4'h0);
                check("rnd s_we",   s_bus.we,    (own >= 0) ? mwe[own]  : 1'b0);
                check("rnd m0_ack", m0_bus.ack,  (own == 0) && sack);
                check("rnd m1_ack", m1_bus.ack,  (own == 1) && sack);
                check("rnd m0_err", m0_bus.err,  (own == 0) && to);
                check("rnd m1_err", m1_bus.err,  (own == 1) && to);
                check("rnd m0_dat", m0_bus.dat_r, (own == 0) ? sdat : 32'h0);
                check("rnd m1_dat", m1_bus.dat_r, (own == 1) ? sdat : 32'h0);
                check("rnd m0 ack&err", m0_bus.ack && m0_bus.err, 1'b0);
            end
            // Advance the model to the state after the coming edge.
            if (rst) begin
                own = -1; last_m = 1'b1; waitc = 0;
            end else begin
                newown = own;
                if (own < 0) begin
                    if (mc[0] && mc[1]) newown = last_m ? 0 : 1;
                    else if (mc[0])     newown = 0;
                    else if (mc[1])     newown = 1;
                end else if (!mc[own]) begin
                    last_m = (own == 1);
                    newown = mc[1 - own] ? (1 - own) : -1;
                end
                waitc = (newown != own || !req || sack || to) ? 0 : waitc + 1;
                own = newown;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
